// File: rtl/row_scan_sequencer.sv
`default_nettype none
// ============================================================================
// row_scan_sequencer
// Steps a decoder select index through the enabled rows with dwell/blank timing.
// Revision 1.0
// ============================================================================
module row_scan_sequencer #(
    parameter int N     = 3,
    parameter int DWELL = 4,
    parameter int BLANK = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [(1<<N)-1:0]   row_mask,
    output logic [N-1:0]        sel,
    output logic                sel_valid,
    output logic                frame_done,
    output logic                busy
);

    localparam int ROWS    = 1 << N;
    localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK > 0) ? BLANK - 1 : 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        BLANKS = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    sel_q, sel_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            sel_valid_q, sel_valid_d;
    logic            frame_done_q, frame_done_d;
    logic            busy_q, busy_d;

    logic [N-1:0]    first_row;
    logic [N-1:0]    nxt_row;
    logic [N-1:0]    scan_idx;
    logic            row_end;

    // Descending loops let the lowest / nearest match overwrite the others.
    always_comb begin
        first_row = '0;
        nxt_row   = sel_q;
        scan_idx  = sel_q;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (row_mask[i]) first_row = N'(i);
        end
        for (int k = ROWS; k >= 1; k--) begin
            scan_idx = sel_q + N'(k);
            if (row_mask[scan_idx]) nxt_row = scan_idx;
        end
    end

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        cnt_d        = cnt_q;
        sel_valid_d  = sel_valid_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        row_end      = 1'b0;

        if (!en) begin
            state_d     = IDLE;
            sel_d       = '0;
            cnt_d       = '0;
            sel_valid_d = 1'b0;
            busy_d      = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d       = '0;
                    sel_d       = '0;
                    sel_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    if (row_mask != '0) begin
                        state_d     = ACTIVE;
                        sel_d       = first_row;
                        sel_valid_d = 1'b1;
                        busy_d      = 1'b1;
                    end
                end
                ACTIVE: begin
                    if (cnt_q == DWELL_LAST) begin
                        if (BLANK > 0) begin
                            state_d     = BLANKS;
                            cnt_d       = '0;
                            sel_valid_d = 1'b0;
                        end else begin
                            row_end = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                BLANKS: begin
                    if (cnt_q == BLANK_LAST) row_end = 1'b1;
                    else                     cnt_d   = cnt_q + 1'b1;
                end
                default: begin
                    state_d     = IDLE;
                    sel_d       = '0;
                    cnt_d       = '0;
                    sel_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end
            endcase

            // The mask is only sampled here, so mid-row changes wait for the boundary.
            if (row_end) begin
                cnt_d = '0;
                if (row_mask == '0) begin
                    state_d     = IDLE;
                    sel_d       = '0;
                    sel_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end else begin
                    state_d      = ACTIVE;
                    sel_d        = nxt_row;
                    sel_valid_d  = 1'b1;
                    busy_d       = 1'b1;
                    frame_done_d = (nxt_row <= sel_q);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            cnt_q        <= '0;
            sel_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            cnt_q        <= cnt_d;
            sel_valid_q  <= sel_valid_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

    assign sel        = sel_q;
    assign sel_valid  = sel_valid_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_row_scan_sequencer.sv
`default_nettype none
// ============================================================================
// tb_row_scan_sequencer
// Directed bench for row_scan_sequencer with hand-computed row sequences.
// Revision 1.0
// ============================================================================
module tb_row_scan_sequencer;

    localparam int N     = 3;
    localparam int DWELL = 4;
    localparam int BLANK = 1;

    logic           clk;
    logic           rst_n;
    logic           en;
    logic [7:0]     row_mask;
    logic [N-1:0]   sel;
    logic           sel_valid;
    logic           frame_done;
    logic           busy;

    int checks = 0;
    int errors = 0;

    row_scan_sequencer #(.N(N), .DWELL(DWELL), .BLANK(BLANK)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .row_mask   (row_mask),
        .sel        (sel),
        .sel_valid  (sel_valid),
        .frame_done (frame_done),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int s, input bit v, input bit f, input bit b);
        check({tag, " sel"},        32'(sel),        32'(s));
        check({tag, " sel_valid"},  32'(sel_valid),  32'(v));
        check({tag, " frame_done"}, 32'(frame_done), 32'(f));
        check({tag, " busy"},       32'(busy),       32'(b));
    endtask

    // Called at the negedge of a row's first cycle; returns at the next row's first cycle.
    task automatic check_row(input int s, input bit fd);
        for (int c = 0; c < DWELL + BLANK; c++) begin
            check_outs($sformatf("row%0d c%0d", s, c), s, (c < DWELL), (c == 0) ? fd : 1'b0, 1'b1);
            @(negedge clk);
        end
    endtask

    task automatic check_idle(input string tag, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            check_outs($sformatf("%s c%0d", tag, c), 0, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        row_mask = 8'h00;
        #3;
        check_outs("reset", 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("post_reset_en0", 3);

        // Full mask: eight rows then the wrap pulse on the return to row 0.
        row_mask = 8'hFF;
        en       = 1'b1;
        @(negedge clk);
        check_row(0, 1'b0);
        for (int r = 1; r < 8; r++) check_row(r, 1'b0);
        check_row(0, 1'b1);
        for (int r = 1; r < 5; r++) check_row(r, 1'b0);

        // Now in dwell cycle 1 of row 5; drop en during dwell cycle 2.
        check_outs("row5 d1", 5, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        check_outs("row5 d2", 5, 1'b1, 1'b0, 1'b1);
        en = 1'b0;
        @(negedge clk);
        check_outs("abort", 0, 1'b0, 1'b0, 1'b0);
        en = 1'b1;
        @(negedge clk);
        check_row(0, 1'b0);
        check_row(1, 1'b0);

        // Sparse mask.
        en = 1'b0;
        @(negedge clk);
        row_mask = 8'b1010_0100;
        en       = 1'b1;
        @(negedge clk);
        check_row(2, 1'b0);
        check_row(5, 1'b0);
        check_row(7, 1'b0);
        check_row(2, 1'b1);
        check_row(5, 1'b0);
        check_row(7, 1'b0);
        check_row(2, 1'b1);

        // Single row.
        en = 1'b0;
        @(negedge clk);
        row_mask = 8'h10;
        en       = 1'b1;
        @(negedge clk);
        check_row(4, 1'b0);
        check_row(4, 1'b1);
        check_row(4, 1'b1);

        // Empty mask keeps the block idle even with en high.
        en = 1'b0;
        @(negedge clk);
        row_mask = 8'h00;
        en       = 1'b1;
        @(negedge clk);
        check_idle("empty_mask", 3);

        // Mask cleared mid-row 3: row 3 completes, then idle.
        row_mask = 8'hFF;
        @(negedge clk);
        check_row(0, 1'b0);
        check_row(1, 1'b0);
        check_row(2, 1'b0);
        check_outs("row3 start", 3, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        row_mask = 8'h00;
        for (int c = 1; c < DWELL + BLANK; c++) begin
            check_outs($sformatf("row3 tail c%0d", c), 3, (c < DWELL), 1'b0, 1'b1);
            @(negedge clk);
        end
        check_idle("after_clear", 2);

        // Asynchronous reset mid-ACTIVE, asserted between clock edges.
        row_mask = 8'hFF;
        @(negedge clk);
        check_outs("pre_async", 0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("async_reset", 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        en    = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("release_en0", 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
